ahb_outstg_rr_arb: RTL and testbench

- Round-robin arbiter that decides which input port drives one bus-matrix output stage (shared AHB slave port).
- Takes per-port requests and the address/control already muxed onto the output. Produces a registered port index plus a no-port flag, which the output stage uses to steer its address and data muxes.
- Keeps ownership for the whole of a defined-length burst and for locked sequences. Re-arbitrates only when HREADYM is high.

---
 rtl/ahb_pkg.sv | 32 +++
 rtl/ahb_outstg_rr_arb_if.sv | 30 +++
 rtl/ahb_rr_pick.sv | 31 +++
 rtl/ahb_outstg_rr_arb.sv | 72 +++++++
 tb/tb_ahb_outstg_rr_arb.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and helpers for the bus-matrix output stages.
//   HTRANS constants : IDLE, BUSY, NONSEQ, SEQ
//   HBURST constants : SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16
//   burst_beats_m1() : number of beats minus one for a defined-length burst, else 0
package ahb_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] WRAP4  = 3'b010;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] WRAP8  = 3'b100;
  localparam logic [2:0] INCR8  = 3'b101;
  localparam logic [2:0] WRAP16 = 3'b110;
  localparam logic [2:0] INCR16 = 3'b111;

  function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
    logic [3:0] beats_m1;
    case (hburst)
      WRAP4,  INCR4:  beats_m1 = 4'd3;
      WRAP8,  INCR8:  beats_m1 = 4'd7;
      WRAP16, INCR16: beats_m1 = 4'd15;
      default:        beats_m1 = 4'd0;  // SINGLE and undefined-length INCR
    endcase
    return beats_m1;
  endfunction

endpackage

// File: rtl/ahb_outstg_rr_arb_if.sv
// Arbiter-side signals of one bus-matrix output stage.
//   req_port     : per-port request (held transfer AND port HSEL)
//   HREADYM      : output-stage HREADYMUX, gates every state update
//   HSELM/HTRANSM/HBURSTM/HMASTLOCKM : control of the currently muxed port
//   addr_in_port : registered index of the port owning the address phase
//   no_port      : registered, 1 = nobody granted
// master = output stage driving the controls, slave = the arbiter.
interface ahb_outstg_rr_arb_if #(
  parameter int unsigned NPORT = 4,
  parameter int unsigned PW    = 2
);
  logic [NPORT-1:0] req_port;
  logic             HREADYM;
  logic             HSELM;
  logic [1:0]       HTRANSM;
  logic [2:0]       HBURSTM;
  logic             HMASTLOCKM;
  logic [PW-1:0]    addr_in_port;
  logic             no_port;

  modport master (
    output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port
  );

  modport slave (
    input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port
  );
endinterface

// File: rtl/ahb_rr_pick.sv
// Combinational rotate-priority picker.
//   req    : request vector, bit i = port i
//   ptr    : last winner; search starts at ptr+1 and wraps, so ptr itself is lowest priority
//   winner : index of the first set request found
//   any    : at least one request is set
module ahb_rr_pick #(
  parameter int unsigned NPORT = 4,
  parameter int unsigned PW    = 2
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    winner,
  output logic             any
);

  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NPORT; i++) begin
      idx = PW'((32'(ptr) + i) % NPORT);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/ahb_outstg_rr_arb.sv
// Round-robin arbiter for one shared AHB output stage.
//   HCLK, HRESETn : clock and asynchronous active-low reset
//   bus (slave)   : requests and muxed control in; registered addr_in_port / no_port out
// Ownership is kept through defined-length bursts and locked sequences; all state moves
// only on HREADYM-high edges.
module ahb_outstg_rr_arb
  import ahb_pkg::*;
#(
  parameter int unsigned NPORT = 4,
  parameter int unsigned PW    = 2
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahb_outstg_rr_arb_if.slave bus
);

  logic [3:0]    cnt_q, cnt_d;
  logic [PW-1:0] port_q, ptr_q;
  logic          none_q;
  logic [PW-1:0] win;
  logic          any;
  logic          hold;

  // Beats still to come in the current burst after this one.
  always_comb begin
    cnt_d = '0;
    if (bus.HSELM) begin
      case (bus.HTRANSM)
        NONSEQ:  cnt_d = burst_beats_m1(bus.HBURSTM);
        SEQ:     cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        BUSY:    cnt_d = cnt_q;
        default: cnt_d = '0;  // IDLE also clears an early-terminated burst
      endcase
    end
  end

  assign hold = !none_q && (bus.HMASTLOCKM || (cnt_d != 4'd0));

  ahb_rr_pick #(
    .NPORT(NPORT),
    .PW   (PW)
  ) u_pick (
    .req   (bus.req_port),
    .ptr   (ptr_q),
    .winner(win),
    .any   (any)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q  <= '0;
      port_q <= '0;
      none_q <= 1'b1;
      ptr_q  <= PW'(NPORT - 1);  // port 0 gets first priority
    end else if (bus.HREADYM) begin
      cnt_q <= cnt_d;
      if (!hold) begin
        if (any) begin
          port_q <= win;
          ptr_q  <= win;
          none_q <= 1'b0;
        end else begin
          none_q <= 1'b1;  // last index is kept for the muxes
        end
      end
    end
  end

  assign bus.addr_in_port = port_q;
  assign bus.no_port      = none_q;

endmodule

// File: tb/tb_ahb_outstg_rr_arb.sv
module tb_ahb_outstg_rr_arb;
  import ahb_pkg::*;

  localparam int unsigned NPORT = 4;
  localparam int unsigned PW    = 2;

  logic HCLK = 1'b0;
  logic HRESETn;

  ahb_outstg_rr_arb_if #(.NPORT(NPORT), .PW(PW)) bus ();

  ahb_outstg_rr_arb #(.NPORT(NPORT), .PW(PW)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, how many beats of the burst remain, last winner.
  int m_owner, m_none, m_left, m_last;
  int len_tab [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_none  = 1;
    m_left  = 0;
    m_last  = NPORT - 1;
  endtask

  task automatic model_edge();
    int left_next;
    bit keep;
    if (!bus.HREADYM) return;
    if (!bus.HSELM || bus.HTRANSM == IDLE) left_next = 0;
    else if (bus.HTRANSM == NONSEQ)        left_next = len_tab[bus.HBURSTM] - 1;
    else if (bus.HTRANSM == SEQ)           left_next = (m_left > 0) ? m_left - 1 : 0;
    else                                   left_next = m_left;
    keep = (m_none == 0) && (bus.HMASTLOCKM || left_next > 0);
    if (!keep) begin
      int found = -1;
      for (int off = 1; off <= NPORT; off++) begin
        int p = (m_last + off) % NPORT;
        if (found < 0 && bus.req_port[p]) found = p;
      end
      if (found >= 0) begin
        m_owner = found;
        m_last  = found;
        m_none  = 0;
      end else begin
        m_none = 1;
      end
    end
    m_left = left_next;
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic cyc(input logic [3:0] req, input logic rdy, input logic sel,
                     input logic [1:0] trans, input logic [2:0] burst, input logic lock);
    bus.req_port   = req;
    bus.HREADYM    = rdy;
    bus.HSELM      = sel;
    bus.HTRANSM    = trans;
    bus.HBURSTM    = burst;
    bus.HMASTLOCKM = lock;
    @(posedge HCLK);
    if (!HRESETn) model_reset();
    else model_edge();
    #1;
    check("addr_in_port", int'(bus.addr_in_port), m_owner);
    check("no_port", int'(bus.no_port), m_none);
  endtask

  initial begin
    HRESETn = 1'b0;
    model_reset();
    bus.req_port = '0; bus.HREADYM = 1'b1; bus.HSELM = 1'b0;
    bus.HTRANSM = IDLE; bus.HBURSTM = SINGLE; bus.HMASTLOCKM = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    check("reset_addr", int'(bus.addr_in_port), 0);
    check("reset_nop", int'(bus.no_port), 1);
    HRESETn = 1'b1;

    // Round-robin between ports 0 and 2
    cyc(4'b0101, 1, 0, IDLE, SINGLE, 0);
    check("first_grant", int'(bus.addr_in_port), 0);
    check("first_grant_nop", int'(bus.no_port), 0);
    cyc(4'b0101, 1, 1, NONSEQ, SINGLE, 0);
    check("rotate_to_2", int'(bus.addr_in_port), 2);

    // INCR4 on port 1 with port 3 waiting
    cyc(4'b0010, 1, 0, IDLE, SINGLE, 0);
    cyc(4'b1010, 1, 1, NONSEQ, INCR4, 0);
    check("incr4_b1", int'(bus.addr_in_port), 1);
    cyc(4'b1010, 1, 1, SEQ, INCR4, 0);
    cyc(4'b1010, 1, 1, SEQ, INCR4, 0);
    check("incr4_b3", int'(bus.addr_in_port), 1);
    cyc(4'b1010, 1, 1, SEQ, INCR4, 0);
    check("incr4_handover", int'(bus.addr_in_port), 3);

    // Same burst with wait states in the middle
    cyc(4'b0010, 1, 0, IDLE, SINGLE, 0);
    cyc(4'b1010, 1, 1, NONSEQ, INCR4, 0);
    cyc(4'b1010, 1, 1, SEQ, INCR4, 0);
    repeat (3) cyc(4'b1111, 0, 1, SEQ, INCR4, 0);
    check("wait_frozen", int'(bus.addr_in_port), 1);
    cyc(4'b1010, 1, 1, SEQ, INCR4, 0);
    check("wait_b3", int'(bus.addr_in_port), 1);
    cyc(4'b1010, 1, 1, SEQ, INCR4, 0);
    check("wait_handover", int'(bus.addr_in_port), 3);

    // Locked SINGLE sequence on port 2 with an IDLE in the middle
    cyc(4'b0100, 1, 0, IDLE, SINGLE, 0);
    cyc(4'b1111, 1, 1, NONSEQ, SINGLE, 1);
    cyc(4'b1111, 1, 1, IDLE, SINGLE, 1);
    cyc(4'b1111, 1, 1, NONSEQ, SINGLE, 1);
    check("lock_held", int'(bus.addr_in_port), 2);
    cyc(4'b1111, 1, 1, NONSEQ, SINGLE, 0);
    check("lock_release", int'(bus.addr_in_port), 3);

    // INCR8 on port 3 cut short by IDLE, port 0 waiting
    cyc(4'b1001, 1, 1, NONSEQ, INCR8, 0);
    cyc(4'b1001, 1, 1, SEQ, INCR8, 0);
    cyc(4'b1001, 1, 1, SEQ, INCR8, 0);
    check("incr8_held", int'(bus.addr_in_port), 3);
    cyc(4'b0001, 1, 1, IDLE, INCR8, 0);
    check("early_term", int'(bus.addr_in_port), 0);

    // No requests after a grant of port 3
    cyc(4'b1000, 1, 0, IDLE, SINGLE, 0);
    repeat (5) cyc(4'b0000, 1, 0, IDLE, SINGLE, 0);
    check("idle_nop", int'(bus.no_port), 1);
    check("idle_addr", int'(bus.addr_in_port), 3);

    // Reset in the middle of INCR16
    cyc(4'b1000, 1, 0, IDLE, SINGLE, 0);
    cyc(4'b1000, 1, 1, NONSEQ, INCR16, 0);
    cyc(4'b1000, 1, 1, SEQ, INCR16, 0);
    HRESETn = 1'b0;
    #1;
    model_reset();
    check("async_rst_addr", int'(bus.addr_in_port), 0);
    check("async_rst_nop", int'(bus.no_port), 1);
    cyc(4'b1111, 1, 1, SEQ, INCR16, 0);
    HRESETn = 1'b1;

    // Random traffic with occasional asynchronous resets
    for (int n = 0; n < 600; n++) begin
      logic [3:0] r;
      logic [1:0] t;
      logic [2:0] b;
      r = 4'($urandom_range(0, 15));
      t = 2'($urandom_range(0, 3));
      b = 3'($urandom_range(0, 7));
      cyc(r, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, t, b,
          $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) begin
        HRESETn = 1'b0;
        #1;
        model_reset();
        check("rnd_rst_addr", int'(bus.addr_in_port), 0);
        check("rnd_rst_nop", int'(bus.no_port), 1);
        #1 HRESETn = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
